// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle mini RISC-V core: opcodes, ALUOp, FSM states, mux selects.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. Counter signals exist only with CTRL_PERF_COUNTERS_EN.
interface multicycle_control_if
`ifdef CTRL_PERF_COUNTERS_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       reg_write;
    logic       illegal_instr;
`ifdef CTRL_PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;
`endif

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write,
               alu_src_a, alu_src_b, alu_op, result_src, reg_write, illegal_instr
`ifdef CTRL_PERF_COUNTERS_EN
        , output cycle_count, instret_count
`endif
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write,
               alu_src_a, alu_src_b, alu_op, result_src, reg_write, illegal_instr
`ifdef CTRL_PERF_COUNTERS_EN
        , input cycle_count, instret_count
`endif
    );
endinterface

// File: rtl/ctrl_perf_counters.sv
// Free-running cycle counter and retired-instruction counter; both wrap modulo 2^CNT_W.
module ctrl_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_i,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instret_count_o
);
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + 1'b1;
        instret_d = retire_i ? instret_q + 1'b1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count_o   = cycle_q;
    assign instret_count_o = instret_q;
endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle core. Define CTRL_PERF_COUNTERS_EN to add
// cycle/instret counters (width CNT_W) on the bus interface.
module multicycle_control
    import riscv_pkg::*;
`ifdef CTRL_PERF_COUNTERS_EN
    #(parameter int CNT_W = 32)
`endif
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_e     state_q, state_d;
    logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_update_c, branch_c;
    logic       reg_write_c, illegal_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, res_c;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        adr_src_c   = 1'b0;
        ir_write_c  = 1'b0;
        pc_update_c = 1'b0;
        branch_c    = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        src_a_c     = SRCA_PC;
        src_b_c     = SRCB_RS2;
        alu_op_c    = ALUOP_ADD;
        res_c       = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                // PC+4 is written straight from the ALU only once the fetch completes.
                mem_req_c   = 1'b1;
                src_b_c     = SRCB_FOUR;
                res_c       = RES_ALU;
                ir_write_c  = bus.mem_ready;
                pc_update_c = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_IMM;
                state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_c       = RES_RDATA;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a_c  = SRCA_RS1;
                alu_op_c = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c  = SRCA_RS1;
                src_b_c  = SRCB_IMM;
                alu_op_c = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                src_a_c  = SRCA_RS1;
                alu_op_c = ALUOP_SUB;
                branch_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // Jump target was formed in DECODE; rd = OldPC+4 is written in ALUWB.
                src_a_c     = SRCA_OLDPC;
                src_b_c     = SRCB_FOUR;
                pc_update_c = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ILLEGAL: illegal_c = 1'b1;
            default:   state_d   = S_FETCH;
        endcase
    end

    assign bus.mem_req       = mem_req_c & ~reset;
    assign bus.mem_write     = mem_write_c & ~reset;
    assign bus.adr_src       = adr_src_c & ~reset;
    assign bus.ir_write      = ir_write_c & ~reset;
    assign bus.pc_write      = (pc_update_c | (branch_c & bus.zero)) & ~reset;
    assign bus.alu_src_a     = reset ? 2'b00 : src_a_c;
    assign bus.alu_src_b     = reset ? 2'b00 : src_b_c;
    assign bus.alu_op        = reset ? 2'b00 : alu_op_c;
    assign bus.result_src    = reset ? 2'b00 : res_c;
    assign bus.reg_write     = reg_write_c & ~reset;
    assign bus.illegal_instr = illegal_c & ~reset;

`ifdef CTRL_PERF_COUNTERS_EN
    logic retire;
    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_MEMWB || state_q == S_ALUWB ||
                     state_q == S_BEQ   || state_q == S_MEMWRITE);

    ctrl_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk             (clk),
        .reset           (reset),
        .retire_i        (retire),
        .cycle_count_o   (bus.cycle_count),
        .instret_count_o (bus.instret_count)
    );
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors queued as stimulus is driven.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef CTRL_PERF_COUNTERS_EN
    multicycle_control_if #(.CNT_W(4)) bus ();
    multicycle_control #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    multicycle_control_if bus ();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        zr;
        logic [6:0]  op;
        logic [14:0] exp;
    } stim_t;

    stim_t       stim_q[$];
    string       stag_q[$];
    logic [14:0] sb_q[$];
    string       sbt_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {mem_req,mem_write,adr_src,ir_write,pc_write,srcA,srcB,aluop,result,reg_write,illegal}
    function automatic logic [14:0] ev(bit rq, bit wr, bit ad, bit ir, bit pw, logic [1:0] a,
                                       logic [1:0] b, logic [1:0] op, logic [1:0] rs, bit rw, bit il);
        return {rq, wr, ad, ir, pw, a, b, op, rs, rw, il};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                bus.reg_write, bus.illegal_instr};
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic put(input bit rst, input bit rdy, input bit zr, input logic [6:0] op,
                       input logic [14:0] exp, input string tag);
        stim_q.push_back('{rst: rst, rdy: rdy, zr: zr, op: op, exp: exp});
        stag_q.push_back(tag);
    endtask

    task automatic fetch(input logic [6:0] op, input int wf, input string nm);
        for (int i = 0; i < wf; i++)
            put(0, 0, rb(), op, ev(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0), {nm, ".fetch_wait"});
        put(0, 1, rb(), op, ev(1,0,0,1,1,2'b00,2'b10,2'b00,2'b10,0,0), {nm, ".fetch"});
        put(0, rb(), rb(), op, ev(0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0), {nm, ".decode"});
    endtask

    task automatic instr(input string nm, input logic [6:0] op, input bit zr, input int wf, input int wm);
        fetch(op, wf, nm);
        case (op)
            7'b0000011, 7'b0100011: begin
                put(0, rb(), rb(), op, ev(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0), {nm, ".memadr"});
                for (int i = 0; i <= wm; i++)
                    if (op == 7'b0000011)
                        put(0, i == wm, rb(), op, ev(1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0), {nm, ".memread"});
                    else
                        put(0, i == wm, rb(), op, ev(1,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0), {nm, ".memwrite"});
                if (op == 7'b0000011)
                    put(0, rb(), rb(), op, ev(0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,1,0), {nm, ".memwb"});
            end
            7'b0110011, 7'b0010011: begin
                put(0, rb(), rb(), op, ev(0,0,0,0,0,2'b10,(op == 7'b0010011) ? 2'b01 : 2'b00,
                                          2'b10,2'b00,0,0), {nm, ".exec"});
                put(0, rb(), rb(), op, ev(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0), {nm, ".aluwb"});
            end
            7'b1100011:
                put(0, rb(), zr, op, ev(0,0,0,0,zr,2'b10,2'b00,2'b01,2'b00,0,0), {nm, ".beq"});
            default: begin
                put(0, rb(), rb(), op, ev(0,0,0,0,1,2'b01,2'b10,2'b00,2'b00,0,0), {nm, ".jal"});
                put(0, rb(), rb(), op, ev(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0), {nm, ".aluwb"});
            end
        endcase
    endtask

    task automatic rst_cycle(input string tag);
        put(1, rb(), rb(), 7'($urandom), 15'h0, tag);
    endtask

    task automatic run_q();
        stim_t s;
        logic [14:0] e;
        string t;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            t = stag_q.pop_front();
            @(posedge clk);
            #1;
            reset         = s.rst;
            bus.mem_ready = s.rdy;
            bus.zero      = s.zr;
            bus.opcode    = s.op;
            sb_q.push_back(s.exp);
            sbt_q.push_back(t);
            @(negedge clk);
            e = sb_q.pop_front();
            chk(sbt_q.pop_front(), {17'h0, observed()}, {17'h0, e});
        end
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.opcode    = 7'h0;

        rst_cycle("reset0");
        rst_cycle("reset1");
        instr("rtype", 7'b0110011, 0, 1, 0);
        instr("lw",    7'b0000011, 0, 0, 3);
        instr("sw",    7'b0100011, 0, 2, 1);
        instr("itype", 7'b0010011, 0, 0, 0);
        instr("beq_t", 7'b1100011, 1, 0, 0);
        instr("beq_n", 7'b1100011, 0, 1, 0);
        instr("jal",   7'b1101111, 0, 0, 0);

        // store abandoned by reset while the request is still pending
        fetch(7'b0100011, 0, "sw_abort");
        put(0, rb(), rb(), 7'b0100011, ev(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0), "sw_abort.memadr");
        put(0, 0, rb(), 7'b0100011, ev(1,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0), "sw_abort.memwrite");
        put(0, 0, rb(), 7'b0100011, ev(1,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0), "sw_abort.memwrite");
        rst_cycle("sw_abort.reset");
        instr("lw2", 7'b0000011, 0, 0, 0);

        fetch(7'b1110011, 0, "ill");
        for (int i = 0; i < 10; i++)
            put(0, rb(), rb(), 7'b1110011, 15'h1, "ill.hold");
        rst_cycle("ill.reset");
        instr("rtype2", 7'b0110011, 0, 0, 0);
        run_q();

`ifdef CTRL_PERF_COUNTERS_EN
        rst_cycle("perf.reset");
        for (int i = 0; i < 16; i++) instr("perf_r", 7'b0110011, 0, 0, 0);
        put(0, 0, 0, 7'b0110011, ev(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0), "perf.fetch_wait");
        run_q();
        chk("cycle_wrap", {28'h0, bus.cycle_count}, 32'd0);
        chk("instret_wrap", {28'h0, bus.instret_count}, 32'd0);
        instr("perf_r17", 7'b0110011, 0, 0, 0);
        put(0, 0, 0, 7'b0110011, ev(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0), "perf.fetch_wait2");
        run_q();
        chk("cycle_after", {28'h0, bus.cycle_count}, 32'd5);
        chk("instret_after", {28'h0, bus.instret_count}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
